// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled, LSB-first, NB_DATA data / NB_STOP stop bits; `UART_RX_SYNC_EN adds a 2-flop input synchronizer.
// Latency: 8 + 16*NB_DATA + 16*NB_STOP ticks + 1 clock from start detect to o_rx_done (+2 clocks with the synchronizer).
// Backpressure: none; o_data is single-buffered and must be captured before the next frame completes.
module uart_rx #(
  parameter int NB_DATA         = 8,
  parameter int NB_STOP         = 1,
  parameter int NB_DATA_COUNTER = $clog2(NB_DATA)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_data,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rx_done,
  output logic               o_frame_error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [NB_DATA_COUNTER-1:0] LAST_BIT  = NB_DATA_COUNTER'(NB_DATA - 1);
  localparam logic                       LAST_STOP = (NB_STOP == 2);

  logic rx;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;

  // Reset to the idle level so a reset never looks like a start edge.
  always_ff @(posedge i_clock) begin
    if (i_reset) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], i_data};
  end

  assign rx = sync_q[1];
`else
  assign rx = i_data;
`endif

  state_t                     state, state_nxt;
  logic [3:0]                 tick_cnt, tick_nxt;
  logic [NB_DATA_COUNTER-1:0] bit_cnt, bit_nxt;
  logic                       stop_cnt, stop_nxt;
  logic [NB_DATA-1:0]         shift_reg, shift_nxt;
  logic                       err, err_nxt;
  logic [NB_DATA-1:0]         data_nxt;
  logic                       done_nxt;
  logic                       ferr_nxt;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      stop_cnt      <= 1'b0;
      shift_reg     <= '0;
      err           <= 1'b0;
      o_data        <= '0;
      o_rx_done     <= 1'b0;
      o_frame_error <= 1'b0;
    end else begin
      state         <= state_nxt;
      tick_cnt      <= tick_nxt;
      bit_cnt       <= bit_nxt;
      stop_cnt      <= stop_nxt;
      shift_reg     <= shift_nxt;
      err           <= err_nxt;
      o_data        <= data_nxt;
      o_rx_done     <= done_nxt;
      o_frame_error <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    stop_nxt  = stop_cnt;
    shift_nxt = shift_reg;
    err_nxt   = err;
    data_nxt  = o_data;
    done_nxt  = 1'b0;
    ferr_nxt  = o_frame_error;

    case (state)
      IDLE: begin
        // Start detect ignores i_tick, so a tick in this cycle is not counted.
        tick_nxt = '0;
        err_nxt  = 1'b0;
        if (!rx) state_nxt = START;
      end

      START: begin
        if (i_tick) begin
          if (tick_cnt == 4'd7) begin
            tick_nxt = '0;
            if (!rx) begin
              bit_nxt   = '0;
              state_nxt = DATA;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            tick_nxt = tick_cnt + 4'd1;
          end
        end
      end

      DATA: begin
        if (i_tick) begin
          if (tick_cnt == 4'd15) begin
            shift_nxt = {rx, shift_reg[NB_DATA-1:1]};
            tick_nxt  = '0;
            if (bit_cnt == LAST_BIT) begin
              stop_nxt  = 1'b0;
              state_nxt = STOP;
            end else begin
              bit_nxt = bit_cnt + NB_DATA_COUNTER'(1);
            end
          end else begin
            tick_nxt = tick_cnt + 4'd1;
          end
        end
      end

      STOP: begin
        if (i_tick) begin
          if (tick_cnt == 4'd15) begin
            err_nxt  = err | ~rx;
            tick_nxt = '0;
            // Complete at mid stop bit so a back-to-back start edge is caught.
            if (stop_cnt == LAST_STOP) begin
              data_nxt  = shift_reg;
              ferr_nxt  = err | ~rx;
              done_nxt  = 1'b1;
              state_nxt = IDLE;
            end else begin
              stop_nxt = stop_cnt + 1'b1;
            end
          end else begin
            tick_nxt = tick_cnt + 4'd1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
